// File: rtl/flip_flop_pkg.sv
// Shared constants and helpers for the flip_flop_reg register/pipeline primitive.
package flip_flop_pkg;

   localparam int FF_DEFAULT_WIDTH = 1;

   function automatic int ff_total_flops(input int width, input int stages);
      return width * stages;
   endfunction

endpackage

// File: rtl/flip_flop_stage.sv
// Single WIDTH-bit register stage: synchronous active-low reset, mux-hold enable.
module flip_flop_stage
   import flip_flop_pkg::*;
#(
   parameter int               WIDTH     = FF_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   // Reset outranks enable; a low en_i holds the value instead of gating the clock.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         q_o <= RESET_VAL;
      end else if (en_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/flip_flop_reg.sv
// Parameterized D register / delay line: STAGES cascaded WIDTH-bit stages sharing reset and enable.
module flip_flop_reg
   import flip_flop_pkg::*;
#(
   parameter int               WIDTH     = FF_DEFAULT_WIDTH,
   parameter int               STAGES    = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   localparam int FLOP_COUNT = ff_total_flops(WIDTH, STAGES);

   if (WIDTH < 1 || STAGES < 1 || FLOP_COUNT < 1) begin : g_param_check
      $fatal(1, "flip_flop_reg: WIDTH and STAGES must both be at least 1");
   end

   logic [WIDTH-1:0] s [STAGES];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] stage_d;

      if (k == 0) begin : g_head
         assign stage_d = d_i;
      end else begin : g_link
         assign stage_d = s[k-1];
      end

      flip_flop_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk_i    (clk_i),
         .reset_ni (reset_ni),
         .en_i     (en_i),
         .d_i      (stage_d),
         .q_o      (s[k])
      );
   end

   assign q_o = s[STAGES-1];

endmodule

// File: tb/tb_flip_flop_reg.sv
// Bench for flip_flop_reg: directed scenarios on a default flop and an 8x3 pipeline, plus random traffic vs. a queue model.
module tb_flip_flop_reg;

   localparam int         P_WIDTH  = 8;
   localparam int         P_STAGES = 3;
   localparam logic [7:0] P_RST    = 8'hA5;

   logic       clk = 1'b0;
   logic       rst_n_d, en_d, d_d, q_d;
   logic       rst_n_p, en_p;
   logic [7:0] d_p, q_p;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   flip_flop_reg u_dut_default (
      .clk_i    (clk),
      .reset_ni (rst_n_d),
      .en_i     (en_d),
      .d_i      (d_d),
      .q_o      (q_d)
   );

   flip_flop_reg #(
      .WIDTH     (P_WIDTH),
      .STAGES    (P_STAGES),
      .RESET_VAL (P_RST)
   ) u_dut_pipe (
      .clk_i    (clk),
      .reset_ni (rst_n_p),
      .en_i     (en_p),
      .d_i      (d_p),
      .q_o      (q_p)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n_d = 1'b0; d_d = 1'b0; en_d = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total_cnt++;
         if (q_d !== 1'b0) $display("FAIL reset_hold[%0d]: q_o=%b required 0", i, q_d);
         else pass_cnt++;
      end
   endtask

   task automatic test_capture();
      rst_n_d = 1'b1; d_d = 1'b1;
      tick();
      total_cnt++;
      if (q_d !== 1'b1) $display("FAIL capture_one: q_o=%b required 1", q_d);
      else pass_cnt++;
      d_d = 1'b0;
      tick();
      total_cnt++;
      if (q_d !== 1'b0) $display("FAIL capture_zero: q_o=%b required 0", q_d);
      else pass_cnt++;
   endtask

   task automatic test_sync_reset_midcycle();
      d_d = 1'b1;
      tick();
      total_cnt++;
      if (q_d !== 1'b1) $display("FAIL midreset_pre: q_o=%b required 1", q_d);
      else pass_cnt++;
      @(negedge clk);
      rst_n_d = 1'b0;
      #1;
      total_cnt++;
      if (q_d !== 1'b1) $display("FAIL midreset_async_leak: q_o=%b required 1", q_d);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (q_d !== 1'b0) $display("FAIL midreset_edge: q_o=%b required 0", q_d);
      else pass_cnt++;
      rst_n_d = 1'b1; d_d = 1'b1;
      tick();
      total_cnt++;
      if (q_d !== 1'b1) $display("FAIL midreset_release: q_o=%b required 1", q_d);
      else pass_cnt++;
   endtask

   task automatic test_enable_hold();
      en_d = 1'b0; d_d = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total_cnt++;
         if (q_d !== 1'b1) $display("FAIL en_hold[%0d]: q_o=%b required 1", i, q_d);
         else pass_cnt++;
      end
      en_d = 1'b1;
      tick();
      total_cnt++;
      if (q_d !== 1'b0) $display("FAIL en_resume: q_o=%b required 0", q_d);
      else pass_cnt++;
      d_d = 1'b1;
      tick();
      total_cnt++;
      if (q_d !== 1'b1) $display("FAIL en_reload: q_o=%b required 1", q_d);
      else pass_cnt++;
      en_d = 1'b0; rst_n_d = 1'b0;
      tick();
      total_cnt++;
      if (q_d !== 1'b0) $display("FAIL reset_over_en: q_o=%b required 0", q_d);
      else pass_cnt++;
      rst_n_d = 1'b1; en_d = 1'b1;
   endtask

   task automatic test_pipeline();
      logic [7:0] feed [5];
      logic [7:0] want [5];
      feed = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      want = '{P_RST, P_RST, 8'h01, 8'h02, 8'h03};
      rst_n_p = 1'b0; en_p = 1'b1; d_p = 8'h00;
      tick();
      total_cnt++;
      if (q_p !== P_RST) $display("FAIL pipe_reset: q_o=%h required %h", q_p, P_RST);
      else pass_cnt++;
      rst_n_p = 1'b1;
      for (int i = 0; i < 5; i++) begin
         d_p = feed[i];
         tick();
         total_cnt++;
         if (q_p !== want[i]) $display("FAIL pipe_seq[%0d]: q_o=%h required %h", i, q_p, want[i]);
         else pass_cnt++;
      end
      en_p = 1'b0; d_p = 8'hFF;
      tick();
      total_cnt++;
      if (q_p !== 8'h03) $display("FAIL pipe_hold: q_o=%h required 03", q_p);
      else pass_cnt++;
      en_p = 1'b1;
   endtask

   // Model: output is the value accepted STAGES enabled edges ago, else the reset value.
   task automatic test_random_pipeline();
      logic [7:0] hist [$];
      logic [7:0] exp_q;
      rst_n_p = 1'b0; en_p = 1'b1; d_p = 8'h00;
      tick();
      hist.delete();
      rst_n_p = 1'b1;
      for (int i = 0; i < 300; i++) begin
         rst_n_p = ($urandom_range(0, 39) != 0);
         en_p    = ($urandom_range(0, 3) != 0);
         d_p     = 8'($urandom);
         if (!rst_n_p) hist.delete();
         else if (en_p) begin
            hist.push_back(d_p);
            if (hist.size() > P_STAGES) void'(hist.pop_front());
         end
         exp_q = (hist.size() == P_STAGES) ? hist[0] : P_RST;
         tick();
         total_cnt++;
         if (q_p !== exp_q) $display("FAIL pipe_random[%0d]: q_o=%h required %h", i, q_p, exp_q);
         else pass_cnt++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_d = 1'b0; en_d = 1'b1; d_d = 1'b0;
      rst_n_p = 1'b0; en_p = 1'b1; d_p = 8'h00;
      #2;
      test_reset();
      test_capture();
      test_sync_reset_midcycle();
      test_enable_hold();
      test_pipeline();
      test_random_pipeline();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
